// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter: FSM encoding, byte width, tag base.
package uart_pkg;
  localparam int              UART_BYTE_W   = 8;
  localparam logic [7:0]      UART_TAG_BASE = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_TAGREL,
    ST_SEND,
    ST_TXREL,
    ST_SRCACK
  } arb_state_e;
endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping at NREQ-1.
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);
  logic [IDW:0] j;

  // Scan offsets high to low so the smallest offset from ptr is the last to win.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + (IDW+1)'(i);
      if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
      if (req[j[IDW-1:0]]) begin
        any = 1'b1;
        idx = j[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ 4-phase byte sources.
// Optional UART_ARB_TAG_EN: prefix each byte with a TAG_BASE|grant_id tag byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
`ifdef UART_ARB_TAG_EN
  , parameter logic [UART_BYTE_W-1:0] TAG_BASE = UART_TAG_BASE
`endif
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [NREQ-1:0]             req,
  input  logic [UART_BYTE_W*NREQ-1:0] data,
  output logic [NREQ-1:0]             ack,
  output logic                        tx_req,
  output logic [UART_BYTE_W-1:0]      tx_data,
  input  logic                        tx_ack,
  output logic                        busy,
  output logic [IDW-1:0]              grant_id
);
  arb_state_e             state_q, state_d;
  logic [NREQ-1:0]        ack_q, ack_d;
  logic                   tx_req_q, tx_req_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;
  logic [IDW-1:0]         gid_q, gid_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
`ifdef UART_ARB_TAG_EN
  logic [UART_BYTE_W-1:0] hold_q, hold_d;
`endif

  logic                   pick_any;
  logic [IDW-1:0]         pick_idx;
  logic [UART_BYTE_W-1:0] src_byte [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_src
    assign src_byte[i] = data[UART_BYTE_W*i +: UART_BYTE_W];
  end

  uart_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
`ifdef UART_ARB_TAG_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      // A lingering tx_ack from the transmitter blocks a new grant.
      ST_IDLE: if (!tx_ack && pick_any) begin
        gid_d    = pick_idx;
        tx_req_d = 1'b1;
`ifdef UART_ARB_TAG_EN
        hold_d    = src_byte[pick_idx];
        tx_data_d = TAG_BASE | UART_BYTE_W'(pick_idx);
        state_d   = ST_TAG;
`else
        tx_data_d = src_byte[pick_idx];
        state_d   = ST_SEND;
`endif
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: if (tx_ack) begin
        tx_req_d = 1'b0;
        state_d  = ST_TAGREL;
      end
      ST_TAGREL: if (!tx_ack) begin
        tx_req_d  = 1'b1;
        tx_data_d = hold_q;
        state_d   = ST_SEND;
      end
`endif
      ST_SEND: if (tx_ack) begin
        tx_req_d = 1'b0;
        state_d  = ST_TXREL;
      end
      ST_TXREL: if (!tx_ack) begin
        ack_d[gid_q] = 1'b1;
        state_d      = ST_SRCACK;
      end
      ST_SRCACK: if (!req[gid_q]) begin
        ack_d   = '0;
        ptr_d   = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      ack_q     <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      gid_q     <= '0;
      ptr_q     <= '0;
`ifdef UART_ARB_TAG_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      gid_q     <= gid_d;
      ptr_q     <= ptr_d;
`ifdef UART_ARB_TAG_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model (ack 3 cycles in, release 1 cycle after).
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic [3:0]      req = '0;
  logic [31:0]     data = '0;
  logic [3:0]      ack;
  logic            tx_req;
  logic [7:0]      tx_data;
  logic            tx_ack = 1'b0;
  logic            busy;
  logic [IDW-1:0]  grant_id;

  int total = 0;
  int bad   = 0;
  logic [7:0] txlog [$];
  int ack_rises = 0;
  logic [3:0] ack_prev = '0;
  int cnt = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Transmitter model plus ack-rise monitor, both on the falling edge.
  always @(negedge clk) begin
    if (tx_req && !tx_ack) begin
      cnt++;
      if (cnt == 3) begin
        tx_ack = 1'b1;
        txlog.push_back(tx_data);
      end
    end else if (!tx_req) begin
      tx_ack = 1'b0;
      cnt    = 0;
    end
    if (ack != 4'h0 && ack_prev == 4'h0) ack_rises++;
    ack_prev = ack;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] first_byte(input int g, input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
    return 8'hA0 | 8'(g);
`else
    return b;
`endif
  endfunction

  task automatic wait_any();
    for (int i = 0; i < 80 && ack == 4'h0; i++) @(negedge clk);
    total++;
    assert (ack != 4'h0) else begin
      bad++;
      $error("FAIL ack_timeout: got %0h want nonzero", ack);
    end
  endtask

  initial begin
    logic [7:0] lastb;
    int n0, r0;

    // 1 reset with all requests asserted
    req  = 4'hF;
    data = 32'h44332211;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_txreq", 32'(tx_req), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_gid", 32'(grant_id), 32'h0);
    end
    req = 4'h0;
    clr = 1'b1;

    // 2 single request on source 2
    @(negedge clk);
    data[23:16] = 8'h5A;
    req = 4'b0100;
    @(negedge clk);
    chk("single_txreq", 32'(tx_req), 32'h1);
    chk("single_txdata", 32'(tx_data), 32'(first_byte(2, 8'h5A)));
    chk("single_gid", 32'(grant_id), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_noack", 32'(ack), 32'h0);
    wait_any();
    chk("single_ack", 32'(ack), 32'h4);
    chk("single_txreq_lo", 32'(tx_req), 32'h0);
    lastb = txlog[$];
    chk("single_byte", 32'(lastb), 32'h5A);
    req = 4'h0;
    @(negedge clk);
    chk("single_ackdrop", 32'(ack), 32'h0);
    chk("single_idle", 32'(busy), 32'h0);

    // 3 round robin from pointer 0
    clr = 1'b0;
    @(negedge clk);
    clr  = 1'b1;
    data = 32'h44332211;
    req  = 4'hF;
    for (int k = 0; k < 6; k++) begin
      int g;
      wait_any();
      g = int'(grant_id);
      chk("rr_gid", 32'(grant_id), 32'(k % 4));
      chk("rr_ack", 32'(ack), 32'(1 << (k % 4)));
      req[g] = 1'b0;
      @(negedge clk);
      chk("rr_ackdrop", 32'(ack), 32'h0);
      req[g] = 1'b1;
    end
    req = 4'h0;
    repeat (3) @(negedge clk);

    // 4 early withdraw on source 1 (pointer is 2)
    r0 = ack_rises;
    data[15:8] = 8'h33;
    req = 4'b0010;
    @(negedge clk);
    req = 4'h0;
    chk("ew_txreq", 32'(tx_req), 32'h1);
    chk("ew_gid", 32'(grant_id), 32'h1);
    chk("ew_txdata", 32'(tx_data), 32'(first_byte(1, 8'h33)));
    wait_any();
    chk("ew_ack", 32'(ack), 32'h2);
    @(negedge clk);
    chk("ew_ack1cyc", 32'(ack), 32'h0);
    chk("ew_idle", 32'(busy), 32'h0);
    lastb = txlog[$];
    chk("ew_byte", 32'(lastb), 32'h33);
    chk("ew_rises", 32'(ack_rises - r0), 32'h1);

    // 5 reset during SEND; pointer must return to 0
    data[31:24] = 8'hC3;
    req = 4'b1000;
    @(negedge clk);
    chk("mr_txreq", 32'(tx_req), 32'h1);
    chk("mr_gid", 32'(grant_id), 32'h3);
    clr = 1'b0;
    @(negedge clk);
    chk("mr_txreq_lo", 32'(tx_req), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_gid0", 32'(grant_id), 32'h0);
    clr = 1'b1;
    data[15:8] = 8'h11;
    req = 4'b1010;
    @(negedge clk);
    chk("mr_ptr0_gid", 32'(grant_id), 32'h1);
    chk("mr_ptr0_data", 32'(tx_data), 32'(first_byte(1, 8'h11)));
    wait_any();
    chk("mr_ack1", 32'(ack), 32'h2);
    req[1] = 1'b0;
    @(negedge clk);
    chk("mr_ack1drop", 32'(ack), 32'h0);
    @(negedge clk);
    chk("mr_gid3", 32'(grant_id), 32'h3);
    chk("mr_data3", 32'(tx_data), 32'(first_byte(3, 8'hC3)));
    wait_any();
    chk("mr_ack3", 32'(ack), 32'h8);
    req = 4'h0;
    repeat (2) @(negedge clk);

    // 6 byte count per grant (two with tag, one without)
    n0 = txlog.size();
    r0 = ack_rises;
    data[15:8] = 8'h41;
    req = 4'b0010;
    wait_any();
    chk("tg_ack", 32'(ack), 32'h2);
    req = 4'h0;
    repeat (3) @(negedge clk);
    chk("tg_rises", 32'(ack_rises - r0), 32'h1);
`ifdef UART_ARB_TAG_EN
    chk("tg_count", 32'(txlog.size() - n0), 32'h2);
    if (txlog.size() >= n0 + 2) begin
      chk("tg_tag", 32'(txlog[n0]), 32'hA1);
      chk("tg_data", 32'(txlog[n0+1]), 32'h41);
    end
`else
    chk("tg_count", 32'(txlog.size() - n0), 32'h1);
    if (txlog.size() >= n0 + 1) chk("tg_data", 32'(txlog[n0]), 32'h41);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
